thermo_pattern_gen: RTL and testbench
=====================================

# thermo_pattern_gen

Self-test source for the TDC stop-decode path. Converts a bin number into the thermometer-coded FF-column word that the delay line would have latched, so the stop decoder can be exercised in-fabric without a physical hit. Supports single-shot emission through a valid/ready handshake and an automatic full-range sweep for code-density checks. Sits in front of the decoder's `wDecodeIn` input behind a test mux; the mux itself is not part of this block.

## Interface
- `NUM_FF`, 64: FF-column width; must be ≥ 6.
- `BITS_DECO`, 8: bin-number width; must satisfy 2^BITS_DECO > NUM_FF.
- `HOLD_CYCLES`, 4: cycles each pattern is held; must be ≥ 1.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `bin_in`  in  BITS_DECO  requested bin.
- `bin_valid`  in  1  `bin_in` is valid.
- `bin_ready`  out  1  block accepts a request this cycle.
- `sweep_start`  in  1  starts a sweep; sampled only in IDLE.
- `sweep_stop`  in  1  ends a sweep after the current hold completes.
- `pattern_out`  out  NUM_FF  generated FF-column word.
- `pattern_valid`  out  1  `pattern_out` is an intended stimulus.
- `expected_bin`  out  BITS_DECO  value the decoder must return for `pattern_out`.
- `range_err`  out  1  one-cycle pulse when an out-of-range request is rejected.
- `sweep_done`  out  1  one-cycle pulse when a sweep ends.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Legal bins: 0 to `NUM_FF-4`.
- Pattern for bin b ≥ 1: bits [b-1:0] = 0, bits [NUM_FF-1:b] = 1. This places one 0→1 edge with at least four trailing ones, and the decoder returns b.
- Pattern for bin 0: all zeros. `expected_bin` = 0.
- FSM states: IDLE, HOLD, SWEEP.
- IDLE:
  - `bin_ready` = 1. `pattern_out`, `pattern_valid`, and `expected_bin` are 0.
  - If `bin_valid` is high and the bin is legal, go to HOLD.
  - If `bin_valid` is high and `bin_in > NUM_FF-4`, pulse `range_err` and stay in IDLE; nothing is emitted.
  - Else if `sweep_start` is high, go to SWEEP with b = 1.
  - If `bin_valid` and `sweep_start` are high in the same cycle, `bin_valid` wins and `sweep_start` is ignored.
- HOLD:
  - Emit the pattern for HOLD_CYCLES cycles with `pattern_valid` = 1.
  - A down-counter counts the hold; when it expires, return to IDLE.
  - `bin_ready` = 0. `sweep_start` and `sweep_stop` are ignored.
- SWEEP:
  - Emit the pattern for b for HOLD_CYCLES cycles, then b increments by 1.
  - After b = `NUM_FF-4` completes, or after the current hold completes if `sweep_stop` was seen, go to IDLE and pulse `sweep_done`.
  - `sweep_stop` is latched when seen; it need not be held high.
  - `bin_ready` = 0.
- Arithmetic:
  - The bin register is BITS_DECO bits; the increment never wraps because the terminal compare is at `NUM_FF-4`.
  - The pattern is generated from a registered bin using a per-bit compare (bit k = (k ≥ b)).

## Timing
- Reset: registered; takes effect on the next edge.
  - All outputs are 0 during reset, including `bin_ready`.
  - `bin_ready` = 1 on the first cycle after `rst` deasserts.
  - Reset in any state returns to IDLE immediately. Pending `sweep_stop`, counters, and the bin register are cleared. No `sweep_done` pulse is produced.
- Handshake: a request accepted on edge n shows its pattern on cycles n+1 to n+HOLD_CYCLES. `bin_ready` returns to 1 on cycle n+HOLD_CYCLES+1.
- `range_err` is high in cycle n+1 only; `bin_ready` remains 1.
- Sweep timing, for `sweep_start` sampled on edge n:
  - Bin 1 appears on cycle n+1.
  - Bins are back-to-back, with no gap cycles and `pattern_valid` held continuously high.
  - A full sweep takes (NUM_FF-4)·HOLD_CYCLES cycles. `sweep_done` is high on the first IDLE cycle.
- `pattern_out`, `pattern_valid`, and `expected_bin` are all registered and change on the same edge.

## Configuration
- `TPG_BUBBLE_EN` defined:
  - Adds input `bubble_en` (1 bit), sampled with the request or `sweep_start`.
  - When set and b ≥ 1, bit b+1 of the pattern is forced to 0, emulating a metastability bubble.
  - `expected_bin` = b+2 when b ≤ `NUM_FF-6`; otherwise 0.
  - In sweep mode the bubble applies to every bin.
- `TPG_BUBBLE_EN` undefined: no `bubble_en` port and no bubble logic. Patterns are always clean.

## Test plan
All scenarios use NUM_FF=64, HOLD_CYCLES=4.
- Single bin: request bin 10 -> `pattern_out` = 64'hFFFF_FFFF_FFFF_FC00 with `expected_bin` = 10 for exactly 4 cycles; `bin_ready` low for those 4 cycles.
- Range edges:
  - bin 0 -> all-zero pattern, `pattern_valid` = 1, `expected_bin` = 0.
  - bin 60 -> top 4 bits set.
  - bin 61 -> `range_err` pulse, no `pattern_valid`.
- Full sweep: `sweep_start` -> bins 1..60 emitted back-to-back, 240 cycles of `pattern_valid`, then one `sweep_done` pulse. Decoder output matches `expected_bin` every cycle.
- Sweep abort:
  - Pulse `sweep_stop` during bin 5 -> bin 5 completes its 4 cycles, then `sweep_done` and IDLE.
  - `bin_valid` and `sweep_start` together in IDLE -> single emission only.
- Reset mid-sweep: assert `rst` during bin 30 -> next cycle all outputs 0 and no `sweep_done`; `bin_ready` = 1 after release.
- Bubble (with `TPG_BUBBLE_EN`): bin 10 with `bubble_en` -> bit 11 cleared, `expected_bin` = 12. Bin 59 with `bubble_en` -> `expected_bin` = 0.

Source files
------------

// File: rtl/thermo_pattern_gen.sv
// thermo_pattern_gen: thermometer-coded FF-column stimulus source for the TDC stop decoder.
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   bin_in/bin_valid/bin_ready  single-shot request handshake
//   sweep_start/sweep_stop    full-range sweep control
//   pattern_out/pattern_valid/expected_bin  registered stimulus and its decode
//   range_err, sweep_done     one-cycle status pulses
//   busy                      high outside IDLE
// Optional: define TPG_BUBBLE_EN to add bubble_en, which clears bit b+1 to emulate a bubble.
module thermo_pattern_gen #(
    parameter int NUM_FF      = 64,
    parameter int BITS_DECO   = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BITS_DECO-1:0] bin_in,
    input  logic                 bin_valid,
    output logic                 bin_ready,
    input  logic                 sweep_start,
    input  logic                 sweep_stop,
`ifdef TPG_BUBBLE_EN
    input  logic                 bubble_en,
`endif
    output logic [NUM_FF-1:0]    pattern_out,
    output logic                 pattern_valid,
    output logic [BITS_DECO-1:0] expected_bin,
    output logic                 range_err,
    output logic                 sweep_done,
    output logic                 busy
);
    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [BITS_DECO-1:0] LAST_BIN = BITS_DECO'(NUM_FF - 4);
    localparam logic [BITS_DECO-1:0] ONE = BITS_DECO'(1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, HOLD, SWEEP} state_t;
    state_t               r_state, w_state_nxt;
    logic [BITS_DECO-1:0] r_bin, w_bin_nxt;
    logic [CW-1:0]        r_cnt, w_cnt_nxt;
    logic                 r_stop, w_stop_nxt;
    logic [NUM_FF-1:0]    r_pattern, w_pat_nxt;
    logic [BITS_DECO-1:0] r_exp, w_exp_nxt;
    logic                 r_pvalid, r_range_err, r_sweep_done;
    logic                 w_req_ok, w_req_bad, w_start, w_hold_end, w_sweep_end, w_emit, w_load;
    assign w_req_ok    = (r_state == IDLE) && bin_valid && (bin_in <= LAST_BIN);
    assign w_req_bad   = (r_state == IDLE) && bin_valid && (bin_in > LAST_BIN);
    assign w_start     = (r_state == IDLE) && !bin_valid && sweep_start;
    assign w_hold_end  = (r_cnt == '0);
    // A stop seen in the final hold cycle itself still ends the sweep at this boundary.
    assign w_sweep_end = (r_state == SWEEP) && w_hold_end && (r_bin == LAST_BIN || r_stop || sweep_stop);
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end
    always_comb begin
        w_state_nxt = (r_state == IDLE) ? (w_req_ok ? HOLD : w_start ? SWEEP : IDLE) :
                      (r_state == HOLD) ? (w_hold_end ? IDLE : HOLD) :
                      (r_state == SWEEP && !w_sweep_end) ? SWEEP : IDLE;
    end
`ifdef TPG_BUBBLE_EN
    logic r_bubble, w_bub_nxt;
    // Bubble mode is captured with the request or sweep start and kept for its duration.
    assign w_bub_nxt = w_emit && ((r_state == IDLE) ? bubble_en : r_bubble);
    assign w_exp_nxt = (w_bub_nxt && w_bin_nxt != '0) ?
                       ((w_bin_nxt <= BITS_DECO'(NUM_FF - 6)) ? w_bin_nxt + BITS_DECO'(2) : '0) : w_bin_nxt;
    always_ff @(posedge clk) begin
        if (rst) r_bubble <= 1'b0;
        else     r_bubble <= w_bub_nxt;
    end
`else
    assign w_exp_nxt = w_bin_nxt;
`endif
    always_comb begin
        w_emit     = (w_state_nxt != IDLE);
        w_load     = w_emit && (r_state == IDLE || w_hold_end);
        w_bin_nxt  = !w_emit ? '0 : w_req_ok ? bin_in : w_start ? ONE :
                     (r_state == SWEEP && w_hold_end) ? r_bin + ONE : r_bin;
        w_cnt_nxt  = w_load ? CNT_LOAD : w_hold_end ? r_cnt : r_cnt - CW'(1);
        w_stop_nxt = (r_state == SWEEP) && w_emit && (r_stop || sweep_stop);
        w_pat_nxt  = '0;
        // Bin 0 is all zeros; any other bin b sets every column at or above b.
        for (int k = 0; k < NUM_FF; k++) begin
            w_pat_nxt[k] = (w_bin_nxt != '0) && (BITS_DECO'(k) >= w_bin_nxt);
`ifdef TPG_BUBBLE_EN
            if (w_bub_nxt && BITS_DECO'(k) == w_bin_nxt + ONE) w_pat_nxt[k] = 1'b0;
`endif
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin        <= '0;
            r_cnt        <= '0;
            r_stop       <= 1'b0;
            r_pattern    <= '0;
            r_exp        <= '0;
            r_pvalid     <= 1'b0;
            r_range_err  <= 1'b0;
            r_sweep_done <= 1'b0;
        end else begin
            r_bin        <= w_bin_nxt;
            r_cnt        <= w_cnt_nxt;
            r_stop       <= w_stop_nxt;
            r_pattern    <= w_pat_nxt;
            r_exp        <= w_exp_nxt;
            r_pvalid     <= w_emit;
            r_range_err  <= w_req_bad;
            r_sweep_done <= w_sweep_end;
        end
    end
    assign bin_ready     = (r_state == IDLE) && !rst;
    assign busy          = (r_state != IDLE);
    assign pattern_out   = r_pattern;
    assign pattern_valid = r_pvalid;
    assign expected_bin  = r_exp;
    assign range_err     = r_range_err;
    assign sweep_done    = r_sweep_done;
endmodule

// File: tb/tb_thermo_pattern_gen.sv
// tb_thermo_pattern_gen: directed self-checking bench for thermo_pattern_gen (NUM_FF=64, HOLD_CYCLES=4).
module tb_thermo_pattern_gen;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  bin_in;
    logic        bin_valid, bin_ready, sweep_start, sweep_stop;
    logic [63:0] pattern_out;
    logic        pattern_valid;
    logic [7:0]  expected_bin;
    logic        range_err, sweep_done, busy;
`ifdef TPG_BUBBLE_EN
    logic        bubble_en;
`endif
    int checks = 0;
    int errors = 0;
    thermo_pattern_gen #(.NUM_FF(64), .BITS_DECO(8), .HOLD_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .bin_in(bin_in), .bin_valid(bin_valid), .bin_ready(bin_ready),
        .sweep_start(sweep_start), .sweep_stop(sweep_stop),
`ifdef TPG_BUBBLE_EN
        .bubble_en(bubble_en),
`endif
        .pattern_out(pattern_out), .pattern_valid(pattern_valid), .expected_bin(expected_bin),
        .range_err(range_err), .sweep_done(sweep_done), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic logic [63:0] thermo(input int b);
        logic [63:0] ones = '1;
        return (b == 0) ? 64'd0 : (ones << b);
    endfunction
    function automatic int decode(input logic [63:0] p);
        for (int k = 0; k < 64; k++) if (p[k]) return k;
        return 0;
    endfunction
    task automatic req(input logic [7:0] b);
        bin_in = b;
        bin_valid = 1'b1;
        cyc();
        bin_valid = 1'b0;
    endtask
    task automatic hold_check(input string tag, input logic [63:0] pat, input int eb);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_pat"}, pattern_out, pat);
            chk({tag, "_exp"}, {56'd0, expected_bin}, 64'(eb));
            chk({tag, "_valid_ready"}, {62'd0, pattern_valid, bin_ready}, 64'b10);
            cyc();
        end
        chk({tag, "_end"}, {61'd0, pattern_valid, bin_ready, busy}, 64'b010);
        chk({tag, "_end_pat"}, pattern_out, 64'd0);
    endtask
    initial begin
        rst = 1'b1; bin_in = '0; bin_valid = 1'b0; sweep_start = 1'b0; sweep_stop = 1'b0;
`ifdef TPG_BUBBLE_EN
        bubble_en = 1'b0;
`endif
        cyc();
        chk("rst_ready", {63'd0, bin_ready}, 64'd0);
        chk("rst_outs", {59'd0, pattern_valid, range_err, sweep_done, busy, |expected_bin}, 64'd0);
        chk("rst_pat", pattern_out, 64'd0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("post_rst_ready", {63'd0, bin_ready}, 64'd1);
        req(8'd10);
        hold_check("bin10", 64'hFFFF_FFFF_FFFF_FC00, 10);
        req(8'd0);
        hold_check("bin0", 64'd0, 0);
        req(8'd60);
        hold_check("bin60", 64'hF000_0000_0000_0000, 60);
        req(8'd61);
        chk("bin61_err", {61'd0, range_err, pattern_valid, bin_ready}, 64'b101);
        chk("bin61_busy", {63'd0, busy}, 64'd0);
        cyc();
        chk("bin61_pulse", {62'd0, range_err, pattern_valid}, 64'd0);
        sweep_start = 1'b1;
        cyc();
        sweep_start = 1'b0;
        for (int i = 0; i < 240; i++) begin
            chk("sweep_pat", pattern_out, thermo(1 + i / 4));
            chk("sweep_exp", {56'd0, expected_bin}, 64'(1 + i / 4));
            chk("sweep_decode", 64'(decode(pattern_out)), {56'd0, expected_bin});
            chk("sweep_flags", {60'd0, pattern_valid, busy, bin_ready, sweep_done}, 64'b1100);
            cyc();
        end
        chk("sweep_done", {60'd0, sweep_done, pattern_valid, busy, bin_ready}, 64'b1001);
        cyc();
        chk("sweep_done_pulse", {63'd0, sweep_done}, 64'd0);
        sweep_start = 1'b1;
        cyc();
        sweep_start = 1'b0;
        repeat (16) cyc();
        chk("abort_bin5", {56'd0, expected_bin}, 64'd5);
        sweep_stop = 1'b1;
        cyc();
        sweep_stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("abort_hold", {55'd0, pattern_valid, expected_bin}, {55'd0, 1'b1, 8'd5});
            chk("abort_nodone", {63'd0, sweep_done}, 64'd0);
            cyc();
        end
        chk("abort_done", {61'd0, sweep_done, pattern_valid, busy}, 64'b100);
        bin_in = 8'd7; bin_valid = 1'b1; sweep_start = 1'b1;
        cyc();
        bin_valid = 1'b0; sweep_start = 1'b0;
        hold_check("both_bin7", thermo(7), 7);
        chk("both_nosweep", {62'd0, sweep_done, pattern_valid}, 64'd0);
        sweep_start = 1'b1;
        cyc();
        sweep_start = 1'b0;
        repeat (116) cyc();
        chk("rst_mid_bin30", {56'd0, expected_bin}, 64'd30);
        rst = 1'b1;
        cyc();
        chk("rst_mid_pat", pattern_out, 64'd0);
        chk("rst_mid_outs", {58'd0, pattern_valid, range_err, sweep_done, busy, bin_ready, |expected_bin}, 64'd0);
        rst = 1'b0;
        cyc();
        chk("rst_mid_release", {61'd0, bin_ready, sweep_done, busy}, 64'b100);
`ifdef TPG_BUBBLE_EN
        bubble_en = 1'b1;
        req(8'd10);
        bubble_en = 1'b0;
        chk("bub10_pat", pattern_out, 64'hFFFF_FFFF_FFFF_F400);
        chk("bub10_exp", {56'd0, expected_bin}, 64'd12);
        repeat (4) cyc();
        bubble_en = 1'b1;
        req(8'd59);
        bubble_en = 1'b0;
        chk("bub59_pat", pattern_out, 64'hE800_0000_0000_0000);
        chk("bub59_exp", {56'd0, expected_bin}, 64'd0);
        repeat (4) cyc();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
